bubble_issue_ctrl: RTL and testbench



---
 rtl/bubble_pkg.sv | 27 ++
 rtl/bubble_issue_ctrl_inflight_sb.sv | 48 ++++
 rtl/bubble_issue_ctrl.sv | 98 +++++++++
 tb/tb_bubble_issue_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bubble_pkg.sv
// Shared definitions for the bubble pipeline: opcode classes, issue FSM states
// and the register-usage helpers used by both the decoder and the issue logic.
package bubble_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_JTYPE = 6'd1;

  typedef enum logic [1:0] {RUN, HAZARD, FLUSH} state_t;

  // Register 0 is hardwired, so it never takes part in a dependency.
  function automatic logic reads_rs(input logic [5:0] op_code, input logic [4:0] rs);
    return (op_code != OP_JTYPE) && (rs != 5'd0);
  endfunction

  function automatic logic reads_rt(input logic [5:0] op_code, input logic [4:0] rt);
    return (op_code == OP_RTYPE) && (rt != 5'd0);
  endfunction

  // Destination register; 0 means "no tracked write".
  function automatic logic [4:0] dest_of(input logic [5:0] op_code, input logic [4:0] rt,
                                         input logic [4:0] rd);
    if (op_code == OP_RTYPE) return rd;
    if (op_code == OP_JTYPE) return 5'd0;
    return rt;
  endfunction

endpackage

// File: rtl/bubble_issue_ctrl_inflight_sb.sv
// In-flight write scoreboard: a WB_LAT-deep shift register of {valid, reg}
// that advances with the execute stage and flags reads of pending writes.
module inflight_sb #(
  parameter int WB_LAT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift,
  input  logic       wr_en,
  input  logic [4:0] wr_reg,
  input  logic       src_a_en,
  input  logic [4:0] src_a,
  input  logic       src_b_en,
  input  logic [4:0] src_b,
  output logic       match
);

  logic [WB_LAT-1:0] valid;
  logic [4:0]        regs [WB_LAT];

  // NOTE: sequential state uses <= so every stage samples its neighbour's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (shift) begin
      valid[0] <= wr_en;
      for (int i = 1; i < WB_LAT; i++) valid[i] <= valid[i-1];
    end
  end

  // NOTE: register tags are not reset; a clear valid bit makes their content irrelevant.
  always_ff @(posedge clk) begin
    if (shift) begin
      regs[0] <= wr_reg;
      for (int i = 1; i < WB_LAT; i++) regs[i] <= regs[i-1];
    end
  end

  // NOTE: combinational outputs get a default first so no path infers a latch.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < WB_LAT; i++) begin
      if (valid[i] && ((src_a_en && regs[i] == src_a) || (src_b_en && regs[i] == src_b)))
        match = 1'b1;
    end
  end

endmodule

// File: rtl/bubble_issue_ctrl.sv
// Issue/hazard controller between decode and execute: stalls on RAW hazards,
// flushes on execute redirects and counts the bubbles it inserts.
module bubble_issue_ctrl
  import bubble_pkg::*;
#(
  parameter int WB_LAT        = 3,
  parameter int FLUSH_BUBBLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic [5:0]       dec_op_code,
  input  logic [4:0]       dec_rs,
  input  logic [4:0]       dec_rt,
  input  logic [4:0]       dec_rd,
  input  logic             ex_redirect,
  input  logic             issue_ready,
  output logic             issue_valid,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int FC_W = (FLUSH_BUBBLES > 1) ? $clog2(FLUSH_BUBBLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_BUBBLES - 1);

  state_t          state, next_state;
  logic [FC_W-1:0] flush_cnt, next_flush_cnt;
  logic            sb_match, hazard, issue_fire, bubble;
  logic [4:0]      dest;

  assign dest = dest_of(dec_op_code, dec_rt, dec_rd);

  inflight_sb #(.WB_LAT(WB_LAT)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift    (issue_ready),
    .wr_en    (issue_fire && (dest != 5'd0)),
    .wr_reg   (dest),
    .src_a_en (reads_rs(dec_op_code, dec_rs)),
    .src_a    (dec_rs),
    .src_b_en (reads_rt(dec_op_code, dec_rt)),
    .src_b    (dec_rt),
    .match    (sb_match)
  );

  assign hazard = dec_valid && sb_match;

  always_comb begin
    next_state     = state;
    next_flush_cnt = flush_cnt;
    issue_valid    = 1'b0;
    flush          = 1'b0;
    if (ex_redirect) begin
      flush          = 1'b1;
      next_state     = FLUSH;
      next_flush_cnt = FC_LOAD;
    end else begin
      unique case (state)
        RUN: begin
          issue_valid = dec_valid && !hazard;
          if (hazard) next_state = HAZARD;
        end
        HAZARD: begin
          issue_valid = dec_valid && !hazard;
          if (!hazard) next_state = RUN;
        end
        FLUSH: begin
          if (issue_ready) begin
            if (flush_cnt == '0) next_state = RUN;
            else                 next_flush_cnt = flush_cnt - 1'b1;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  assign issue_fire = issue_valid && issue_ready;
  assign stall      = !flush && ((dec_valid && !issue_fire) || (state == FLUSH));
  // A redirect cycle kills whatever sits in decode, so it is a bubble as well.
  assign bubble     = issue_ready && !issue_fire && (ex_redirect || state == FLUSH || hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      state     <= next_state;
      flush_cnt <= next_flush_cnt;
      if (bubble && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bubble_issue_ctrl.sv
// Directed bench for bubble_issue_ctrl; a second CNT_W=4 instance on the same
// inputs exercises counter saturation.
module tb_bubble_issue_ctrl;
  import bubble_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid;
  logic [5:0]  dec_op_code;
  logic [4:0]  dec_rs, dec_rt, dec_rd;
  logic        ex_redirect, issue_ready;
  logic        issue_valid, stall, flush;
  logic [15:0] bubble_cnt;
  logic        issue_valid4, stall4, flush4;
  logic [3:0]  bubble_cnt4;

  int tests  = 0;
  int failed = 0;
  int exp_bc = 0;

  bubble_issue_ctrl #(.WB_LAT(3), .FLUSH_BUBBLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_op_code(dec_op_code),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd), .ex_redirect(ex_redirect),
    .issue_ready(issue_ready), .issue_valid(issue_valid), .stall(stall),
    .flush(flush), .bubble_cnt(bubble_cnt)
  );

  bubble_issue_ctrl #(.WB_LAT(3), .FLUSH_BUBBLES(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_op_code(dec_op_code),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd), .ex_redirect(ex_redirect),
    .issue_ready(issue_ready), .issue_valid(issue_valid4), .stall(stall4),
    .flush(flush4), .bubble_cnt(bubble_cnt4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd);
    dec_valid   = v;
    dec_op_code = op;
    dec_rs      = rs;
    dec_rt      = rt;
    dec_rd      = rd;
  endtask

  // Inputs are already driven; check outputs mid-cycle, then advance one clock.
  task automatic cyc(input string tag, input logic iv, input logic st, input logic fl);
    #1;
    check({tag, ".issue_valid"}, 32'(issue_valid), 32'(iv));
    check({tag, ".stall"},       32'(stall),       32'(st));
    check({tag, ".flush"},       32'(flush),       32'(fl));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bc(input string tag);
    check({tag, ".bubble_cnt"},  32'(bubble_cnt),  32'(exp_bc));
    check({tag, ".bubble_cnt4"}, 32'(bubble_cnt4), (exp_bc > 15) ? 32'd15 : 32'(exp_bc));
  endtask

  task automatic idle(input int n);
    drive(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
    repeat (n) cyc("idle", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    ex_redirect = 1'b0;
    issue_ready = 1'b1;
    drive(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
    #3;
    check("reset.issue_valid", 32'(issue_valid), 32'd0);
    check("reset.stall",       32'(stall),       32'd0);
    check("reset.flush",       32'(flush),       32'd0);
    check("reset.state",       32'(dut.state),   32'(RUN));
    chk_bc("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // RAW on rd=5 from an R-type producer: three bubbles, then issue.
    drive(1'b1, OP_RTYPE, 5'd1, 5'd2, 5'd5);
    cyc("raw_prod", 1'b1, 1'b0, 1'b0);
    drive(1'b1, OP_RTYPE, 5'd5, 5'd0, 5'd6);
    cyc("raw_s0", 1'b0, 1'b1, 1'b0);
    check("raw.state", 32'(dut.state), 32'(HAZARD));
    cyc("raw_s1", 1'b0, 1'b1, 1'b0);
    cyc("raw_s2", 1'b0, 1'b1, 1'b0);
    exp_bc += 3;
    chk_bc("raw");
    cyc("raw_issue", 1'b1, 1'b0, 1'b0);
    idle(3);

    // I-type reads only rs; an R-type reading rt=7 waits for both writers to retire.
    drive(1'b1, 6'd8, 5'd1, 5'd7, 5'd0);
    cyc("itype_prod", 1'b1, 1'b0, 1'b0);
    drive(1'b1, 6'd8, 5'd0, 5'd7, 5'd0);
    cyc("itype_nordt", 1'b1, 1'b0, 1'b0);
    drive(1'b1, OP_RTYPE, 5'd0, 5'd7, 5'd9);
    repeat (3) cyc("itype_rt_stall", 1'b0, 1'b1, 1'b0);
    exp_bc += 3;
    chk_bc("itype");
    cyc("itype_rt_issue", 1'b1, 1'b0, 1'b0);
    idle(3);

    // Register 0 never creates a dependency.
    drive(1'b1, OP_RTYPE, 5'd1, 5'd2, 5'd0);
    cyc("zero_prod", 1'b1, 1'b0, 1'b0);
    drive(1'b1, OP_RTYPE, 5'd0, 5'd0, 5'd3);
    cyc("zero_cons", 1'b1, 1'b0, 1'b0);
    chk_bc("zero");
    idle(3);

    // Redirect: one flush cycle, two stall cycles, then RUN.
    drive(1'b1, OP_RTYPE, 5'd1, 5'd2, 5'd3);
    ex_redirect = 1'b1;
    cyc("redir", 1'b0, 1'b0, 1'b1);
    ex_redirect = 1'b0;
    check("redir.state", 32'(dut.state), 32'(FLUSH));
    cyc("redir_f0", 1'b0, 1'b1, 1'b0);
    cyc("redir_f1", 1'b0, 1'b1, 1'b0);
    check("redir_run.state", 32'(dut.state), 32'(RUN));
    exp_bc += 3;
    chk_bc("redir");
    cyc("redir_issue", 1'b1, 1'b0, 1'b0);

    // A redirect inside FLUSH restarts the bubble count.
    drive(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0);
    ex_redirect = 1'b1;
    cyc("redir2_a", 1'b0, 1'b0, 1'b1);
    ex_redirect = 1'b0;
    cyc("redir2_f", 1'b0, 1'b1, 1'b0);
    ex_redirect = 1'b1;
    cyc("redir2_b", 1'b0, 1'b0, 1'b1);
    ex_redirect = 1'b0;
    cyc("redir2_f0", 1'b0, 1'b1, 1'b0);
    cyc("redir2_f1", 1'b0, 1'b1, 1'b0);
    check("redir2.state", 32'(dut.state), 32'(RUN));
    exp_bc += 5;
    chk_bc("redir2");
    idle(3);

    // Backpressure during a hazard freezes scoreboard and counter.
    drive(1'b1, OP_RTYPE, 5'd1, 5'd2, 5'd5);
    cyc("bp_prod", 1'b1, 1'b0, 1'b0);
    drive(1'b1, OP_RTYPE, 5'd5, 5'd0, 5'd6);
    issue_ready = 1'b0;
    repeat (4) cyc("bp_hold", 1'b0, 1'b1, 1'b0);
    chk_bc("bp_hold");
    issue_ready = 1'b1;
    repeat (3) cyc("bp_stall", 1'b0, 1'b1, 1'b0);
    exp_bc += 3;
    chk_bc("bp");
    cyc("bp_issue", 1'b1, 1'b0, 1'b0);
    idle(3);

    // Asynchronous reset in the middle of a hazard.
    drive(1'b1, OP_RTYPE, 5'd1, 5'd2, 5'd5);
    cyc("ar_prod", 1'b1, 1'b0, 1'b0);
    drive(1'b1, OP_RTYPE, 5'd5, 5'd0, 5'd6);
    cyc("ar_stall", 1'b0, 1'b1, 1'b0);
    check("ar_pre.state", 32'(dut.state), 32'(HAZARD));
    #2 rst_n = 1'b0;
    #1;
    exp_bc = 0;
    check("ar.state",       32'(dut.state),   32'(RUN));
    check("ar.issue_valid", 32'(issue_valid), 32'd1);
    check("ar.stall",       32'(stall),       32'd0);
    chk_bc("ar");
    #1 rst_n = 1'b1;
    cyc("ar_first", 1'b1, 1'b0, 1'b0);
    idle(3);

    // Twenty bubbles: the 4-bit counter saturates at 15.
    ex_redirect = 1'b1;
    repeat (20) cyc("sat_redir", 1'b0, 1'b0, 1'b1);
    exp_bc += 20;
    chk_bc("sat20");
    ex_redirect = 1'b0;
    cyc("sat_f0", 1'b0, 1'b1, 1'b0);
    cyc("sat_f1", 1'b0, 1'b1, 1'b0);
    exp_bc += 2;
    chk_bc("sat22");
    cyc("sat_run", 1'b0, 1'b0, 1'b0);
    check("sat.state", 32'(dut.state), 32'(RUN));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
